// File: rtl/imuldiv_seq.sv
// Sequential integer multiply/divide unit with HI/LO registers; 32 run cycles plus one sign-fix cycle.
// Latency 34 cycles from issue to HI/LO update; any non-IDLE op presented while busy is held off via o_stall.
`ifndef CPU_DATA_WIDTH
`define CPU_DATA_WIDTH 32
`endif
`ifndef CPU_IMDOP_WIDTH
`define CPU_IMDOP_WIDTH 4
`define CPU_IMDOP_IDLE 4'd0
`define CPU_IMDOP_MUL  4'd1
`define CPU_IMDOP_MULU 4'd2
`define CPU_IMDOP_DIV  4'd3
`define CPU_IMDOP_DIVU 4'd4
`define CPU_IMDOP_MFHI 4'd5
`define CPU_IMDOP_MFLO 4'd6
`define CPU_IMDOP_MTHI 4'd7
`define CPU_IMDOP_MTLO 4'd8
`endif

module imuldiv_seq (
    input  logic                        clk,
    input  logic                        nrst,
    input  logic [`CPU_IMDOP_WIDTH-1:0] i_imuldiv_op,
    input  logic [`CPU_DATA_WIDTH-1:0]  i_rs,
    input  logic [`CPU_DATA_WIDTH-1:0]  i_rt,
    input  logic                        i_ext_stall,
    input  logic                        i_flush,
    output logic                        o_stall,
    output logic                        o_busy,
    output logic [`CPU_DATA_WIDTH-1:0]  o_result
);

    typedef enum logic [1:0] {S_IDLE, S_RUN_MUL, S_RUN_DIV, S_SIGN} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opb_q, opb_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        na_q, na_d;
    logic        nb_q, nb_d;
    logic        div_q, div_d;
    logic        dz_q, dz_d;

    logic        is_mul, is_div, is_signed;
    logic [31:0] abs_rs, abs_rt;
    logic [32:0] mul_sum, rem_sh, diff;
    logic [63:0] prod;
    logic [31:0] quo, rem;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            acc_q   <= 64'd0;
            opb_q   <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            na_q    <= 1'b0;
            nb_q    <= 1'b0;
            div_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            na_q    <= na_d;
            nb_q    <= nb_d;
            div_q   <= div_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        na_d    = na_q;
        nb_d    = nb_q;
        div_d   = div_q;
        dz_d    = dz_q;

        is_mul    = (i_imuldiv_op == `CPU_IMDOP_MUL) || (i_imuldiv_op == `CPU_IMDOP_MULU);
        is_div    = (i_imuldiv_op == `CPU_IMDOP_DIV) || (i_imuldiv_op == `CPU_IMDOP_DIVU);
        is_signed = (i_imuldiv_op == `CPU_IMDOP_MUL) || (i_imuldiv_op == `CPU_IMDOP_DIV);
        abs_rs    = (is_signed && i_rs[31]) ? (32'd0 - i_rs) : i_rs;
        abs_rt    = (is_signed && i_rt[31]) ? (32'd0 - i_rt) : i_rt;

        // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
        mul_sum = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opb_q : 32'd0)};
        rem_sh  = {acc_q[63:32], acc_q[31]};
        diff    = rem_sh - {1'b0, opb_q};

        prod = (na_q ^ nb_q) ? (64'd0 - acc_q) : acc_q;
        quo  = (na_q ^ nb_q) ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
        rem  = na_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

        case (state_q)
            S_IDLE: begin
                if (!i_ext_stall) begin
                    if (is_mul || is_div) begin
                        state_d = is_div ? S_RUN_DIV : S_RUN_MUL;
                        cnt_d   = 5'd0;
                        acc_d   = {32'd0, (is_div ? abs_rs : abs_rt)};
                        opb_d   = is_div ? abs_rt : abs_rs;
                        na_d    = is_signed & i_rs[31];
                        nb_d    = is_signed & i_rt[31];
                        div_d   = is_div;
                        dz_d    = (i_rt == 32'd0);
                    end else if (i_imuldiv_op == `CPU_IMDOP_MTHI) begin
                        hi_d = i_rs;
                    end else if (i_imuldiv_op == `CPU_IMDOP_MTLO) begin
                        lo_d = i_rs;
                    end
                end
            end
            S_RUN_MUL: begin
                acc_d = {mul_sum, acc_q[31:1]};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = S_SIGN;
            end
            S_RUN_DIV: begin
                // a zero divisor never borrows, leaving all-ones quotient and the dividend as remainder
                acc_d = diff[32] ? {rem_sh[31:0], acc_q[30:0], 1'b0}
                                 : {diff[31:0], acc_q[30:0], 1'b1};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = S_SIGN;
            end
            S_SIGN: begin
                state_d = S_IDLE;
                if (div_q) begin
                    hi_d = rem;
                    lo_d = dz_q ? 32'hFFFF_FFFF : quo;
                end else begin
                    hi_d = prod[63:32];
                    lo_d = prod[31:0];
                end
            end
            default: state_d = S_IDLE;
        endcase

        // flush overrides issue, MT writes and the sign-fix write-back
        if (i_flush) begin
            state_d = S_IDLE;
            cnt_d   = 5'd0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    assign o_busy   = (state_q != S_IDLE);
    assign o_stall  = o_busy && (i_imuldiv_op != `CPU_IMDOP_IDLE);
    assign o_result = (i_imuldiv_op == `CPU_IMDOP_MFHI) ? hi_q :
                      (i_imuldiv_op == `CPU_IMDOP_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_imuldiv_seq.sv
// Bench for imuldiv_seq: directed corner vectors plus random ops against a plain-arithmetic model.
module tb_imuldiv_seq;

    localparam logic [3:0] OP_IDLE = 4'd0, OP_MUL = 4'd1, OP_MULU = 4'd2, OP_DIV = 4'd3,
                           OP_DIVU = 4'd4, OP_MFHI = 4'd5, OP_MFLO = 4'd6, OP_MTHI = 4'd7,
                           OP_MTLO = 4'd8;

    logic        clk = 1'b0;
    logic        nrst;
    logic [3:0]  op;
    logic [31:0] rs, rt;
    logic        ext_stall, flush;
    logic        stall, busy;
    logic [31:0] result;

    int          total = 0;
    int          bad = 0;
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

    imuldiv_seq dut (
        .clk(clk), .nrst(nrst), .i_imuldiv_op(op), .i_rs(rs), .i_rt(rt),
        .i_ext_stall(ext_stall), .i_flush(flush), .o_stall(stall), .o_busy(busy), .o_result(result)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_res(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p = 64'd0;
        case (o)
            OP_MUL:  begin q = sa * sb; p = q; end
            OP_MULU: p = {32'd0, a} * {32'd0, b};
            OP_DIV:  if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                     else begin q = sa / sb; r = sa % sb; p = {r[31:0], q[31:0]}; end
            OP_DIVU: if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                     else p = {a % b, a / b};
            default: p = 64'd0;
        endcase
        return p;
    endfunction

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    // Present an op for one cycle, then count busy cycles (bounded) until the unit idles.
    task automatic exec(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic hold_ext, output int nbusy);
        @(negedge clk);
        op = o; rs = a; rt = b;
        @(negedge clk);
        op = OP_IDLE;
        ext_stall = hold_ext;
        nbusy = 0;
        while (busy && nbusy < 100) begin
            nbusy++;
            @(negedge clk);
        end
        ext_stall = 1'b0;
    endtask

    task automatic rd(output logic [31:0] h, output logic [31:0] l);
        op = OP_MFHI; #1 h = result;
        op = OP_MFLO; #1 l = result;
        op = OP_IDLE; #1;
    endtask

    task automatic test_reset();
        logic [31:0] h, l;
        nrst = 1'b0; op = OP_IDLE; rs = 32'd0; rt = 32'd0; ext_stall = 1'b0; flush = 1'b0;
        #12;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        op = OP_MUL; #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall); end
        total++; if (result !== 32'd0) begin bad++; $display("FAIL reset_result got=%h want=0", result); end
        op = OP_IDLE;
        rd(h, l);
        total++; if ({h, l} !== 64'd0) begin bad++; $display("FAIL reset_hilo got=%h_%h want=0", h, l); end
        @(negedge clk); nrst = 1'b1;
    endtask

    task automatic test_directed();
        logic [3:0]  vop [6] = '{OP_MULU, OP_MUL, OP_DIV, OP_DIVU, OP_DIV, OP_DIV};
        logic [31:0] va  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h1234_5678, 32'h8000_0000, 32'hFFFF_FFF9};
        logic [31:0] vb  [6] = '{32'hFFFF_FFFF, 32'd5, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] eh  [6] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678, 32'd0, 32'hFFFF_FFF9};
        logic [31:0] el  [6] = '{32'h0000_0001, 32'hFFFF_FFF1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] h, l;
        int nb;
        for (int i = 0; i < 6; i++) begin
            exec(vop[i], va[i], vb[i], 1'b0, nb);
            rd(h, l);
            total++; if (nb !== 33) begin bad++; $display("FAIL dir%0d_busy got=%0d want=33", i, nb); end
            total++; if (h !== eh[i]) begin bad++; $display("FAIL dir%0d_hi got=%h want=%h", i, h, eh[i]); end
            total++; if (l !== el[i]) begin bad++; $display("FAIL dir%0d_lo got=%h want=%h", i, l, el[i]); end
            m_hi = eh[i]; m_lo = el[i];
        end
    endtask

    task automatic test_random();
        logic [3:0]  o;
        logic [31:0] a, b, h, l;
        int nb;
        for (int i = 0; i < 40; i++) begin
            o = 4'($urandom_range(1, 4));
            a = pick_val();
            b = pick_val();
            exec(o, a, b, 1'b0, nb);
            {m_hi, m_lo} = ref_res(o, a, b);
            rd(h, l);
            total++; if (nb !== 33) begin bad++; $display("FAIL rnd%0d_busy got=%0d want=33", i, nb); end
            total++; if ({h, l} !== {m_hi, m_lo})
                begin bad++; $display("FAIL rnd%0d op=%0d a=%h b=%h got=%h_%h want=%h_%h", i, o, a, b, h, l, m_hi, m_lo); end
        end
    endtask

    task automatic test_stall_mf();
        logic [31:0] a, b;
        int n;
        a = $urandom; b = $urandom;
        @(negedge clk);
        op = OP_MUL; rs = a; rt = b; #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL issue_stall got=%b want=0", stall); end
        {m_hi, m_lo} = ref_res(OP_MUL, a, b);
        @(negedge clk);
        op = OP_MFLO; #1;
        n = 0;
        while (stall && n < 100) begin n++; @(negedge clk); #1; end
        total++; if (n !== 33) begin bad++; $display("FAIL mflo_stall_cycles got=%0d want=33", n); end
        total++; if (result !== m_lo) begin bad++; $display("FAIL mflo_after_stall got=%h want=%h", result, m_lo); end
        op = OP_IDLE;
    endtask

    task automatic test_mt();
        logic [31:0] h, l;
        int nb;
        @(negedge clk); op = OP_MTLO; rs = 32'hA5A5_A5A5;
        @(negedge clk); op = OP_IDLE;
        rd(h, l);
        total++; if (l !== 32'hA5A5_A5A5) begin bad++; $display("FAIL mtlo got=%h want=a5a5a5a5", l); end
        m_lo = 32'hA5A5_A5A5;
        @(negedge clk); op = OP_MTHI; rs = 32'h1357_9BDF;
        @(negedge clk); op = OP_IDLE;
        rd(h, l);
        total++; if (h !== 32'h1357_9BDF) begin bad++; $display("FAIL mthi got=%h want=13579bdf", h); end
        m_hi = 32'h1357_9BDF;
        // MTHI held for a few busy cycles, withdrawn before completion
        @(negedge clk); op = OP_MULU; rs = 32'd7; rt = 32'd9;
        @(negedge clk); op = OP_MTHI; rs = 32'hDEAD_BEEF; #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL mthi_busy_stall got=%b want=1", stall); end
        repeat (4) @(negedge clk);
        op = OP_IDLE;
        nb = 0;
        while (busy && nb < 100) begin nb++; @(negedge clk); end
        rd(h, l);
        total++; if ({h, l} !== 64'd63) begin bad++; $display("FAIL mthi_while_busy got=%h_%h want=0_3f", h, l); end
        m_hi = 32'd0; m_lo = 32'd63;
    endtask

    task automatic test_ext_stall();
        logic [31:0] h, l;
        int nb;
        @(negedge clk); ext_stall = 1'b1; op = OP_MUL; rs = 32'd5; rt = 32'd5;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ext_stall_issue got=%b want=0", busy); end
        op = OP_MTHI; rs = 32'hCAFE_F00D;
        @(negedge clk); op = OP_IDLE; ext_stall = 1'b0;
        rd(h, l);
        total++; if (h !== m_hi) begin bad++; $display("FAIL ext_stall_mthi got=%h want=%h", h, m_hi); end
        exec(OP_MULU, 32'h0001_0000, 32'h0003_0000, 1'b1, nb);
        rd(h, l);
        total++; if (nb !== 33) begin bad++; $display("FAIL ext_stall_run_busy got=%0d want=33", nb); end
        total++; if ({h, l} !== 64'h3_0000_0000) begin bad++; $display("FAIL ext_stall_run got=%h_%h want=3_0", h, l); end
        {m_hi, m_lo} = 64'h3_0000_0000;
    endtask

    task automatic test_flush();
        int ks [2] = '{10, 33};
        logic [31:0] h, l;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); op = OP_DIVU; rs = 32'hFFFF_0000; rt = 32'd3;
            @(negedge clk); op = OP_IDLE;
            for (int c = 1; c < ks[i]; c++) @(negedge clk);
            flush = 1'b1;
            @(negedge clk); flush = 1'b0; #1;
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_t%0d_busy got=%b want=0", ks[i], busy); end
            rd(h, l);
            total++; if ({h, l} !== {m_hi, m_lo})
                begin bad++; $display("FAIL flush_t%0d_hilo got=%h_%h want=%h_%h", ks[i], h, l, m_hi, m_lo); end
        end
        @(negedge clk); op = OP_MUL; rs = 32'd3; rt = 32'd3; flush = 1'b1;
        @(negedge clk); op = OP_IDLE; flush = 1'b0; #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_blocks_issue got=%b want=0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, c, d, h, l;
        int n, nb;
        a = $urandom; b = $urandom; c = $urandom; d = $urandom_range(1, 1000);
        @(negedge clk); op = OP_MUL; rs = a; rt = b;
        @(negedge clk); op = OP_DIV; rs = c; rt = d; #1;
        n = 0;
        while (stall && n < 100) begin n++; @(negedge clk); #1; end
        total++; if (n !== 33) begin bad++; $display("FAIL b2b_stall got=%0d want=33", n); end
        @(negedge clk); op = OP_IDLE;
        nb = 0;
        while (busy && nb < 100) begin nb++; @(negedge clk); end
        {m_hi, m_lo} = ref_res(OP_DIV, c, d);
        rd(h, l);
        total++; if (nb !== 33) begin bad++; $display("FAIL b2b_busy got=%0d want=33", nb); end
        total++; if ({h, l} !== {m_hi, m_lo}) begin bad++; $display("FAIL b2b_hilo got=%h_%h want=%h_%h", h, l, m_hi, m_lo); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] h, l;
        int nb;
        @(negedge clk); op = OP_MUL; rs = 32'hFFFF_FFF0; rt = 32'd77;
        @(negedge clk); op = OP_IDLE;
        repeat (14) @(negedge clk);
        nrst = 1'b0; #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
        rd(h, l);
        total++; if ({h, l} !== 64'd0) begin bad++; $display("FAIL midrst_hilo got=%h_%h want=0", h, l); end
        @(negedge clk); nrst = 1'b1;
        op = OP_MULU; rs = 32'd2; rt = 32'd3;
        @(negedge clk); op = OP_IDLE; #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_first_edge got=%b want=1", busy); end
        nb = 0;
        while (busy && nb < 100) begin nb++; @(negedge clk); end
        rd(h, l);
        total++; if ({h, l} !== 64'd6) begin bad++; $display("FAIL midrst_mulu got=%h_%h want=0_6", h, l); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_stall_mf();
        test_mt();
        test_ext_stall();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
